// File: rtl/div_sng_pkg.sv
// Shared constants and types for the division stochastic number generator.
// Seeds, LFSR taps and the controller state encoding live here.
package div_sng_pkg;

  localparam int unsigned SNG_WIDTH = 6;

  // Fibonacci taps for x^6 + x^5 + 1
  localparam int unsigned TAP_HI = 5;
  localparam int unsigned TAP_LO = 4;

  localparam logic [SNG_WIDTH-1:0] DEF_SEED_A = 6'h01;
  localparam logic [SNG_WIDTH-1:0] DEF_SEED_B = 6'h15;
  localparam logic [SNG_WIDTH-1:0] DEF_SEED_C = 6'h2A;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

endpackage

// File: rtl/sng_lfsr.sv
// Maximal-length Fibonacci LFSR with synchronous seed load and step enable.
// The reset value is a parameter so it stays a constant for the async reset.
module sng_lfsr
  import div_sng_pkg::*;
#(
  parameter int unsigned          WIDTH   = SNG_WIDTH,
  parameter logic [WIDTH-1:0]     RST_VAL = DEF_SEED_A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  output logic [WIDTH-1:0] state
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_VAL;
    end else if (load) begin
      state <= seed;
    end else if (en) begin
      state <= {state[WIDTH-2:0], state[TAP_HI] ^ state[TAP_LO]};
    end
  end

endmodule

// File: rtl/div_sng.sv
// Stream controller producing dividend/divisor bitstreams and a quotient
// comparator random number from three independent LFSRs.
module div_sng
  import div_sng_pkg::*;
#(
  parameter int unsigned          WIDTH  = SNG_WIDTH,
  parameter int unsigned          LEN_W  = 10,
  parameter logic [WIDTH-1:0]     SEED_A = DEF_SEED_A,
  parameter logic [WIDTH-1:0]     SEED_B = DEF_SEED_B,
  parameter logic [WIDTH-1:0]     SEED_C = DEF_SEED_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend_val,
  input  logic [WIDTH-1:0] divisor_val,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             bit_valid,
  output logic             dividend,
  output logic             divisor,
  output logic [WIDTH-1:0] rand_num,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dividend_val_q, divisor_val_q;
  logic [LEN_W-1:0] cnt_q;
  logic             load;
  logic             run;
  logic [WIDTH-1:0] lfsr_a, lfsr_b, lfsr_c;

  assign run = (state_q == StRun);

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len != '0) begin
            state_d = StRun;
            load    = 1'b1;
          end else begin
            state_d = StFin;
          end
        end
      end
      StRun: begin
        // cnt_q holds the number of bits still to emit, including this one
        if (cnt_q == LEN_W'(1)) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      dividend_val_q <= '0;
      divisor_val_q  <= '0;
      cnt_q          <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        dividend_val_q <= dividend_val;
        divisor_val_q  <= divisor_val;
        cnt_q          <= len;
      end else if (run) begin
        cnt_q <= cnt_q - LEN_W'(1);
      end
    end
  end

  sng_lfsr #(.WIDTH(WIDTH), .RST_VAL(SEED_A)) u_lfsr_a (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .seed  (SEED_A),
    .en    (run),
    .state (lfsr_a)
  );

  sng_lfsr #(.WIDTH(WIDTH), .RST_VAL(SEED_B)) u_lfsr_b (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .seed  (SEED_B),
    .en    (run),
    .state (lfsr_b)
  );

  sng_lfsr #(.WIDTH(WIDTH), .RST_VAL(SEED_C)) u_lfsr_c (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .seed  (SEED_C),
    .en    (run),
    .state (lfsr_c)
  );

  always_comb begin
    busy      = run;
    bit_valid = run;
    done      = (state_q == StFin);
    dividend  = run & (dividend_val_q > lfsr_a);
    divisor   = run & (divisor_val_q > lfsr_b);
    rand_num  = run ? lfsr_c : '0;
  end

endmodule

// File: tb/tb_div_sng.sv
// Scoreboard bench for div_sng: stimulus queues expected bits and stream
// summaries, a negedge monitor pops and compares as the DUT produces them.
module tb_div_sng;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] dividend_val;
  logic [5:0] divisor_val;
  logic [9:0] len;
  logic       busy;
  logic       bit_valid;
  logic       dividend;
  logic       divisor;
  logic [5:0] rand_num;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       dvd;
    logic       dvs;
    logic [5:0] rn;
    logic [5:0] a;
  } bit_exp_t;

  typedef struct packed {
    logic [15:0] n_bits;
    logic [15:0] dvd_ones;
    logic [15:0] dvs_ones;
  } sum_exp_t;

  bit_exp_t bit_q[$];
  sum_exp_t sum_q[$];

  // Hand-derived stream for dividend_val=9, divisor_val=32 from the default seeds
  bit_exp_t seq_tab[6];
  initial begin
    seq_tab[0] = '{dvd: 1'b1, dvs: 1'b1, rn: 6'h2A, a: 6'h01};
    seq_tab[1] = '{dvd: 1'b1, dvs: 1'b0, rn: 6'h15, a: 6'h02};
    seq_tab[2] = '{dvd: 1'b1, dvs: 1'b1, rn: 6'h2B, a: 6'h04};
    seq_tab[3] = '{dvd: 1'b1, dvs: 1'b0, rn: 6'h17, a: 6'h08};
    seq_tab[4] = '{dvd: 1'b0, dvs: 1'b1, rn: 6'h2F, a: 6'h10};
    seq_tab[5] = '{dvd: 1'b0, dvs: 1'b0, rn: 6'h1F, a: 6'h21};
  end

  div_sng dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dividend_val (dividend_val),
    .divisor_val  (divisor_val),
    .len          (len),
    .busy         (busy),
    .bit_valid    (bit_valid),
    .dividend     (dividend),
    .divisor      (divisor),
    .rand_num     (rand_num),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " bit_valid"}, int'(bit_valid), 0);
    chk({tag, " dividend"}, int'(dividend), 0);
    chk({tag, " divisor"}, int'(divisor), 0);
    chk({tag, " rand_num"}, int'(rand_num), 0);
  endtask

  // Called just after a posedge with the DUT idle; start is sampled at the next edge.
  task automatic start_stream(input logic [5:0] dv, input logic [5:0] sv, input logic [9:0] l);
    start        = 1'b1;
    dividend_val = dv;
    divisor_val  = sv;
    len          = l;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic push_seq();
    for (int i = 0; i < 6; i++) bit_q.push_back(seq_tab[i]);
    sum_q.push_back('{n_bits: 16'd6, dvd_ones: 16'd4, dvs_ones: 16'd3});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: done not seen within %0d cycles", name, budget);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: accumulates per-stream statistics and compares against the queues
  initial begin
    int       n_bits, d_ones, s_ones;
    logic     prev_valid, prev_done;
    bit_exp_t be;
    sum_exp_t se;
    n_bits = 0; d_ones = 0; s_ones = 0;
    prev_valid = 1'b0; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_bits = 0; d_ones = 0; s_ones = 0;
        prev_valid = 1'b0; prev_done = 1'b0;
      end else begin
        if (prev_done) chk("done single pulse", int'(done), 0);
        if (bit_valid) begin
          n_bits++;
          d_ones += int'(dividend);
          s_ones += int'(divisor);
          if (bit_q.size() > 0) begin
            be = bit_q.pop_front();
            chk("seq dividend", int'(dividend), int'(be.dvd));
            chk("seq divisor", int'(divisor), int'(be.dvs));
            chk("seq rand_num", int'(rand_num), int'(be.rn));
            chk("seq lfsr_a", int'(dut.u_lfsr_a.state), int'(be.a));
          end
        end else begin
          chk("idle bitstream zero", int'({dividend, divisor, rand_num}), 0);
        end
        if (done) begin
          if (sum_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected done: got 1 expected 0");
          end else begin
            se = sum_q.pop_front();
            chk("stream length", n_bits, int'(se.n_bits));
            chk("dividend ones", d_ones, int'(se.dvd_ones));
            chk("divisor ones", s_ones, int'(se.dvs_ones));
            chk("done after last bit", int'(prev_valid), int'(se.n_bits != 0));
            chk("busy low at done", int'(busy), 0);
          end
          n_bits = 0; d_ones = 0; s_ones = 0;
        end
        prev_valid = bit_valid;
        prev_done  = done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    dividend_val = '0;
    divisor_val = '0;
    len = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed sequence, seeds from reset
    push_seq();
    start_stream(6'd9, 6'd32, 10'd6);
    wait_done("seq", 20);

    // Zero-length stream: done exactly one cycle after start, no bits
    sum_q.push_back('{n_bits: 16'd0, dvd_ones: 16'd0, dvs_ones: 16'd0});
    start_stream(6'd40, 6'd40, 10'd0);
    @(negedge clk);
    chk("len0 done latency", int'(done), 1);
    chk("len0 bit_valid", int'(bit_valid), 0);
    @(posedge clk);
    #1;

    // Full-period ones counts
    sum_q.push_back('{n_bits: 16'd63, dvd_ones: 16'd62, dvs_ones: 16'd0});
    start_stream(6'd63, 6'd0, 10'd63);
    wait_done("full 63/0", 100);

    sum_q.push_back('{n_bits: 16'd63, dvd_ones: 16'd31, dvs_ones: 16'd0});
    start_stream(6'd32, 6'd1, 10'd63);
    wait_done("full 32/1", 100);

    // Two periods: LFSRs wrap without reseed
    sum_q.push_back('{n_bits: 16'd126, dvd_ones: 16'd62, dvs_ones: 16'd124});
    start_stream(6'd32, 6'd63, 10'd126);
    wait_done("wrap 126", 200);

    // Start during RUN with new operands must be ignored
    sum_q.push_back('{n_bits: 16'd63, dvd_ones: 16'd62, dvs_ones: 16'd0});
    start_stream(6'd63, 6'd0, 10'd63);
    repeat (5) @(posedge clk);
    #1;
    start_stream(6'd0, 6'd63, 10'd5);
    wait_done("collision", 100);
    repeat (2) @(negedge clk);
    chk("collision no restart", int'(busy), 0);
    @(posedge clk);
    #1;

    // Reset at k=10 of a long stream aborts with no done
    start_stream(6'd63, 6'd0, 10'd63);
    repeat (10) @(posedge clk);
    #1;
    chk("pre-abort bit_valid", int'(bit_valid), 1);
    rst = 1'b1;
    #1;
    chk_outputs_zero("async abort");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no done after abort", int'(done), 0);
    end
    @(posedge clk);
    #1;

    // Fresh start reproduces the sequence from the seeds
    push_seq();
    start_stream(6'd9, 6'd32, 10'd6);
    wait_done("seq after reset", 20);

    repeat (3) @(negedge clk);
    chk("bit queue drained", bit_q.size(), 0);
    chk("summary queue drained", sum_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_sng.md
DIV_SNG -- requirements
Module: div_sng

Interface
REQ-001 Parameter WIDTH, 6: operand and random-number width (fixed).
REQ-002 Parameter LEN_W, 10: width of the stream-length field.
REQ-003 Parameters SEED_A / SEED_B / SEED_C, 6'h01 / 6'h15 / 6'h2A: per-LFSR seeds; each nonzero.
REQ-004 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port start, input, 1: single-cycle request to begin a stream.
REQ-007 Port dividend_val, input, WIDTH: binary dividend operand, sampled on an accepted start.
REQ-008 Port divisor_val, input, WIDTH: binary divisor operand, sampled on an accepted start.
REQ-009 Port len, input, LEN_W: stream length in cycles, sampled on an accepted start.
REQ-010 Port busy, output, 1: a stream is in progress.
REQ-011 Port bit_valid, output, 1: dividend, divisor and rand_num are valid this cycle.
REQ-012 Port dividend, output, 1: dividend bitstream bit for the downstream divider.
REQ-013 Port divisor, output, 1: divisor bitstream bit for the downstream divider.
REQ-014 Port rand_num, output, WIDTH: random number for the divider's quotient comparator.
REQ-015 Port done, output, 1: one-cycle pulse marking stream completion.

Function
REQ-016 Three independent Fibonacci LFSRs (A, B, C), polynomial x^6+x^5+1, next = {s[4:0], s[5]^s[4]}, period 63, never zero.
REQ-017 FSM states: IDLE, RUN, FIN.
REQ-018 IDLE, start=1, len>0: latch operands and len, load LFSRs A/B/C with SEED_A/B/C, and enter RUN next cycle.
REQ-019 IDLE, start=1, len=0: go to FIN with no valid bits.
REQ-020 start in RUN or FIN is ignored; latched operands and len are unchanged.
REQ-021 RUN: busy=1, bit_valid=1, for exactly the latched len cycles, stream index k=0..len-1.
REQ-022 At index k: dividend = (dividend_val_q > A_k), divisor = (divisor_val_q > B_k), rand_num = C_k, where A_0 = SEED_A.
REQ-023 Each LFSR advances exactly once per cycle in which bit_valid=1; it holds otherwise.
REQ-024 Over 63 consecutive bits, the count of ones equals max(v-1, 0) for operand v.
REQ-025 len > 63 wraps the LFSR sequence naturally with no reseed; the length counter is LEN_W bits and saturates nowhere.
REQ-026 After the last RUN cycle: go to FIN; done=1 and busy=0 for one cycle, then return to IDLE.
REQ-027 Outside RUN: bit_valid=0, dividend=0, divisor=0, rand_num=0.
REQ-028 All outputs are driven from registers or from registers through comparators only; inputs have no combinational path to outputs.

Reset
REQ-029 When rst is asserted, the FSM goes to IDLE immediately (asynchronously).
REQ-030 On reset, LFSRs take SEED_A/B/C, latched operands and len go to 0, and every output reads 0.
REQ-031 Reset asserted mid-stream aborts the stream without a done pulse; the first start after deassertion behaves per REQ-018.

Structure
REQ-032 Package div_sng_pkg holds the WIDTH constant, the LFSR tap constants, the default seeds and the FSM state enum.
REQ-033 One sub-module, sng_lfsr (ports: clk, rst, load, seed, en, state), is instantiated three times.

Verification
REQ-034 Reset: assert rst -> busy=0, done=0, bit_valid=0, dividend=0, divisor=0, rand_num=0.
REQ-035 Ones count: dividend_val=63, divisor_val=0, len=63 -> exactly 62 dividend ones and 0 divisor ones; dividend_val=32 -> 31 ones.
REQ-036 Sequence check: start with len=6 -> rand_num (seed 6'h2A) and A-states follow REQ-016; from A=01: 01, 02, 04, 08, 10, 21; done pulses in the cycle after the sixth valid bit.
REQ-037 len=0: start -> done one cycle later; bit_valid never asserts.
REQ-038 Collision: start pulse during RUN with new operands -> ignored; the stream length and bit counts match the first request.
REQ-039 Reset mid-stream: rst at k=10 of len=63 -> outputs 0 immediately and no done; a fresh start reproduces the sequence from the seeds.
